// File: rtl/scalar_enc.sv
// Message encoder: loads N serial message bits, maps each bit to 0 or t, adds
// signed noise, reduces modulo q and streams the coefficients over valid/ready.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | shifting msg_bit into the message register, one index per cycle
// EMIT  | producing coefficients through the output register
// DONE  | one-cycle completion pulse
module scalar_enc #(
    parameter int N  = 1024,
    parameter int W  = 30,
    parameter int NW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 msg_bit,
    input  logic [W-1:0]         t,
    input  logic [W-1:0]         q,
    input  logic [NW-1:0]        noise,
    output logic [W-1:0]         coeff_out,
    output logic                 coeff_valid,
    input  logic                 coeff_ready,
    output logic [$clog2(N)-1:0] coeff_idx,
    output logic                 busy,
    output logic                 done
);

    localparam int AW = $clog2(N);
    localparam int VW = W + 2;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  msg;
    logic [AW-1:0] cnt;
    logic          rem;
    logic          load_en;
    logic          hs;
    logic [VW-1:0] base_v;
    logic [VW-1:0] q_v;
    logic [VW-1:0] q2_v;
    logic [VW-1:0] v;
    logic [W-1:0]  enc;

    assign hs      = coeff_valid && coeff_ready;
    assign load_en = (state == S_EMIT) && rem && (!coeff_valid || coeff_ready);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = S_EMIT;
            end
            S_EMIT: begin
                busy = 1'b1;
                if (hs && coeff_idx == LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // v = base + q + noise lies in (0, 3q), so at most two subtractions of q reduce it.
    always_comb begin
        base_v = msg[cnt] ? {2'b00, t} : '0;
        q_v    = {2'b00, q};
        q2_v   = {1'b0, q, 1'b0};
        v      = base_v + q_v + {{(VW - NW){noise[NW-1]}}, noise};
        if (v >= q2_v) begin
            enc = W'(v - q2_v);
        end else if (v >= q_v) begin
            enc = W'(v - q_v);
        end else begin
            enc = W'(v);
        end
    end

    // Message bits carry no reset: every frame rewrites all N of them before use.
    always_ff @(posedge clk) begin
        if (state == S_LOAD) msg[cnt] <= msg_bit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rem         <= 1'b0;
            coeff_out   <= '0;
            coeff_valid <= 1'b0;
            coeff_idx   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) cnt <= '0;
                end
                S_LOAD: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        rem <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            if (load_en) begin
                coeff_out   <= enc;
                coeff_idx   <= cnt;
                coeff_valid <= 1'b1;
                cnt         <= cnt + 1'b1;
                if (cnt == LAST) rem <= 1'b0;
            end else if (hs) begin
                coeff_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/scalar_enc.md
# scalar_enc

Message encoder for the homomorphic-encryption datapath: the inverse of the coefficient decoder. It loads a serial stream of `N` message bits and maps each bit to a coefficient, bit 1 to `t` and bit 0 to `0`. It adds a small signed noise term, reduces the result modulo `q`, and streams the `N` coefficients out over a valid/ready handshake. The output feeds the encryption/polynomial-arithmetic stage; a decoder downstream recovers each bit by testing `|coeff - t| < t_half`.

## Interface
Parameters:
- `N`, 1024: coefficients per polynomial (power of two).
- `W`, 30: coefficient width.
- `NW`, 8: noise width, two's complement.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: begin a frame; sampled only in IDLE.
- `msg_bit` input 1: message bit, sampled every LOAD cycle.
- `t` input W: encoding scale; must satisfy `t < q`; held stable from `start` to `done`.
- `q` input W: modulus; held stable from `start` to `done`.
- `noise` input NW: signed noise for the coefficient being produced; requires `|noise| < q`.
- `coeff_out` output W: encoded coefficient, registered.
- `coeff_valid` output 1: `coeff_out` holds a valid coefficient.
- `coeff_ready` input 1: downstream accepts the coefficient.
- `coeff_idx` output log2(N): index of the coefficient on `coeff_out`.
- `busy` output 1: high in LOAD and EMIT.
- `done` output 1: one-cycle pulse after the last handshake.

## Operation
- Storage is an `N`-bit message register plus a log2(N)-bit counter. Bit storage is not cleared by reset.
- FSM states:
  - IDLE: `start`=1 goes to LOAD, counter=0.
  - LOAD: each cycle stores `msg_bit` at index counter and increments the counter. After index N-1 the counter returns to 0 and the state goes to EMIT.
  - EMIT: see the output register rules below. After the handshake of index N-1 the state goes to DONE.
  - DONE: `done`=1 for exactly this cycle, then IDLE.
- Output register load condition: state EMIT, coefficients remaining, and (`coeff_valid`=0 or `coeff_ready`=1). On that edge:
  - `coeff_out` takes enc(bit[counter], noise).
  - `coeff_idx` takes counter.
  - `coeff_valid` is set to 1 and the counter increments.
  - `noise` is sampled on the same edge.
- Handshake completes on an edge with `coeff_valid`=1 and `coeff_ready`=1. If no new coefficient loads on that edge, `coeff_valid` clears.
- While `coeff_valid`=1 and `coeff_ready`=0, `coeff_out`, `coeff_idx` and `coeff_valid` hold; `noise` is not consumed.
- Arithmetic for enc(b, n):
  - base = b ? t : 0.
  - v = base + q + sext(n), computed in W+2 bits; v lies in (0, 3q).
  - If v ≥ 2q, result = v − 2q; else if v ≥ q, result = v − q; else result = v.
  - Result is always in [0, q).
- `start` is ignored outside IDLE. A frame may be restarted immediately after DONE; there is no sticky completion flag.
- `reset` low at any time:
  - State goes to IDLE, counter to 0.
  - `coeff_out`=0, `coeff_valid`=0, `coeff_idx`=0, `busy`=0, `done`=0.
  - A partially loaded or partially emitted frame is discarded.

## Timing
- Reset values: all outputs 0.
- With `start` seen in IDLE at edge E0:
  - `busy`=1 from E0.
  - Bits are sampled at edges E1..EN, index 0..N-1.
  - EMIT occupies the cycle after EN.
  - The first `coeff_valid` rises after edge EN+1.
- With `coeff_ready` held high:
  - Throughput is one coefficient per cycle.
  - The last coefficient (index N-1) is valid after EN+N.
  - `done` is high after EN+N+1, and `busy` falls in the same cycle.
  - Total is 2N+2 cycles from `start` to `done`.
- Backpressure adds exactly one cycle of latency per stalled cycle and drops or duplicates no coefficient.
- `coeff_valid` never falls without a handshake, except on reset.

## Test plan
- **Zero frame.** N=1024, q=536870909, t=268435454, all bits 0, noise 0, ready=1. Required: 1024 coefficients all 0, `coeff_idx` 0..1023 in order, `done` exactly 2050 cycles after `start`.
- **Bit and noise mix.** Bit pattern alternating 1,0, noise +5 / −3. Required: even indices give 268435459, odd indices give q−3 = 536870906.
- **Wrap-around.** t=q−2, bit 1, noise +5 gives 3; bit 0, noise −127 gives q−127. A reference model checks every coefficient in [0, q).
- **Backpressure.** ready driven with a random 30% duty. Required: `coeff_out`/`coeff_idx` stable while stalled, all 1024 indices delivered exactly once and in order, `done` delayed by exactly the stall count.
- **Reset mid-operation.** `reset` low at LOAD index 500, then again at EMIT index 700. Required: all outputs 0 immediately. A following clean frame encodes correctly with no residue from the aborted frame.
- **Start during busy.** `start` pulsed during LOAD and EMIT. Required: ignored, frame unaffected. `start` in the cycle after DONE starts a new frame.
